// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register of the five-stage
// MIPS core. Owns the program counter, chooses the next fetch address
// (sequential, branch target, jump target), consumes instruction memory read
// data when imem_ready is high, and loads the decode-stage registers. Memory
// wait cycles and wrong-path fetches become NOP bubbles in decode.
//
// Ports
//   clk, reset        pipeline clock; synchronous active-high reset
//   stallF, stallD    hazard-unit freezes for the PC and IF/ID register
//   pcsrcD/pcbranchD  taken branch resolved in decode and its target
//   jumpD/pcjumpD     jump in decode and its target (wins over a branch)
//   pcF               current fetch address to instruction memory
//   instrF            instruction memory read data for pcF
//   imem_ready        instrF is valid this cycle
//   instrD, pcplus4D  instruction in decode and its PC+4
//   validD            0 when instrD is a bubble/flush
//   fetchcnt          instructions accepted into decode
//   bubblecnt         bubbles and flushes inserted into decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000  // sll $0,$0,0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic [31:0] pcF,
  input  logic [31:0] instrF,
  input  logic        imem_ready,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [31:0] fetchcnt,
  output logic [31:0] bubblecnt
);

  // Contents of the IF/ID register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifIdT;

  localparam ifIdT BUBBLE = '{instr: NOP_INSTR, pcPlus4: 32'h0, valid: 1'b0};

  // What the IF/ID register does this cycle.
  typedef enum logic [1:0] {
    ID_HOLD,
    ID_BUBBLE,
    ID_LOAD
  } idActT;

  logic [31:0] pcReg;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4F;
  logic [31:0] redirectTarget;
  logic        redirect;
  ifIdT        ifIdReg;
  ifIdT        ifIdNext;
  idActT       idAct;
  logic [31:0] fetchCntReg;
  logic [31:0] bubbleCntReg;

  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pcPlus4F       = pcReg + 32'd4;
  assign redirect       = jumpD | pcsrcD;
  assign redirectTarget = jumpD ? pcjumpD : pcbranchD;

  // Next PC. A redirect abandons the in-flight fetch even while memory is
  // still busy; stallF freezes the PC and swallows any redirect.
  always_comb begin
    pcNext = pcReg;
    if (stallF)          pcNext = pcReg;
    else if (redirect)   pcNext = redirectTarget;
    else if (imem_ready) pcNext = pcPlus4F;
  end

  // IF/ID action. Hold wins over everything; the instruction fetched in a
  // redirect cycle is on the wrong path, so it is replaced with a NOP, as is
  // a cycle where memory has nothing to give.
  always_comb begin
    idAct    = ID_LOAD;
    ifIdNext = '{instr: instrF, pcPlus4: pcPlus4F, valid: 1'b1};
    if (stallD) begin
      idAct    = ID_HOLD;
      ifIdNext = ifIdReg;
    end else if (redirect || !imem_ready) begin
      idAct    = ID_BUBBLE;
      ifIdNext = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg        <= RESET_PC;
      ifIdReg      <= BUBBLE;
      fetchCntReg  <= 32'h0;
      bubbleCntReg <= 32'h0;
    end else begin
      pcReg   <= pcNext;
      ifIdReg <= ifIdNext;
      if (idAct == ID_LOAD)   fetchCntReg  <= fetchCntReg + 32'd1;
      if (idAct == ID_BUBBLE) bubbleCntReg <= bubbleCntReg + 32'd1;
    end
  end

  assign pcF       = pcReg;
  assign instrD    = ifIdReg.instr;
  assign pcplus4D  = ifIdReg.pcPlus4;
  assign validD    = ifIdReg.valid;
  assign fetchcnt  = fetchCntReg;
  assign bubblecnt = bubbleCntReg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, pcsrcD, jumpD, imem_ready;
  logic [31:0] pcbranchD, pcjumpD, pcF, instrF, instrD, pcplus4D;
  logic        validD;
  logic [31:0] fetchcnt, bubblecnt;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  // Instruction memory: contents derived from the address.
  assign instrF = 32'h2008_0001 + pcF;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD),
    .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .pcF(pcF), .instrF(instrF), .imem_ready(imem_ready), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .fetchcnt(fetchcnt), .bubblecnt(bubblecnt)
  );

  // Advance one edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pcbranchD = 32'h0; pcjumpD = 32'h0; imem_ready = 1'b1;
    step(); step();
    nChecks++; if (pcF !== 32'h0) begin nErrors++; $display("FAIL reset_pc: got %h want %h", pcF, 32'h0); end
    nChecks++; if (instrD !== 32'h0) begin nErrors++; $display("FAIL reset_instr: got %h want %h", instrD, 32'h0); end
    nChecks++; if (validD !== 1'b0) begin nErrors++; $display("FAIL reset_valid: got %b want 0", validD); end
    nChecks++; if (fetchcnt !== 32'h0 || bubblecnt !== 32'h0) begin nErrors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetchcnt, bubblecnt); end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    step();
    nChecks++; if (pcF !== 32'h4) begin nErrors++; $display("FAIL seq_pc1: got %h want %h", pcF, 32'h4); end
    nChecks++; if (instrD !== 32'h2008_0001 || pcplus4D !== 32'h4 || validD !== 1'b1) begin nErrors++; $display("FAIL seq_id1: got %h/%h/%b want 20080001/00000004/1", instrD, pcplus4D, validD); end
    step();
    nChecks++; if (pcF !== 32'h8) begin nErrors++; $display("FAIL seq_pc2: got %h want %h", pcF, 32'h8); end
    nChecks++; if (instrD !== 32'h2008_0005 || pcplus4D !== 32'h8) begin nErrors++; $display("FAIL seq_id2: got %h/%h want 20080005/00000008", instrD, pcplus4D); end
    nChecks++; if (fetchcnt !== 32'd2) begin nErrors++; $display("FAIL seq_cnt2: got %0d want 2", fetchcnt); end
  endtask

  task automatic test_stall();
    stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // A redirect during a full stall must be ignored.
      jumpD = (i == 1); pcjumpD = 32'h300;
      step();
      nChecks++; if (pcF !== 32'h8) begin nErrors++; $display("FAIL stall_pc%0d: got %h want %h", i, pcF, 32'h8); end
      nChecks++; if (instrD !== 32'h2008_0005 || pcplus4D !== 32'h8 || validD !== 1'b1) begin nErrors++; $display("FAIL stall_id%0d: got %h/%h/%b want 20080005/00000008/1", i, instrD, pcplus4D, validD); end
      nChecks++; if (fetchcnt !== 32'd2 || bubblecnt !== 32'd0) begin nErrors++; $display("FAIL stall_cnt%0d: got %0d/%0d want 2/0", i, fetchcnt, bubblecnt); end
    end
    stallF = 1'b0; stallD = 1'b0; jumpD = 1'b0;
    step();
    nChecks++; if (pcF !== 32'hC) begin nErrors++; $display("FAIL stall_rel_pc: got %h want %h", pcF, 32'hC); end
    nChecks++; if (instrD !== 32'h2008_0009 || fetchcnt !== 32'd3) begin nErrors++; $display("FAIL stall_rel_id: got %h/%0d want 20080009/3", instrD, fetchcnt); end
    step();
    nChecks++; if (pcF !== 32'h10 || fetchcnt !== 32'd4) begin nErrors++; $display("FAIL seq_pc4: got %h/%0d want 00000010/4", pcF, fetchcnt); end
  endtask

  task automatic test_branch();
    pcsrcD = 1'b1; pcbranchD = 32'h40;
    step();
    nChecks++; if (pcF !== 32'h40) begin nErrors++; $display("FAIL br_pc: got %h want %h", pcF, 32'h40); end
    nChecks++; if (instrD !== 32'h0 || pcplus4D !== 32'h0 || validD !== 1'b0) begin nErrors++; $display("FAIL br_flush: got %h/%h/%b want 0/0/0", instrD, pcplus4D, validD); end
    nChecks++; if (bubblecnt !== 32'd1 || fetchcnt !== 32'd4) begin nErrors++; $display("FAIL br_cnt: got %0d/%0d want 4/1", fetchcnt, bubblecnt); end
    pcsrcD = 1'b0;
    step();
    nChecks++; if (instrD !== 32'h2008_0041 || pcplus4D !== 32'h44 || validD !== 1'b1) begin nErrors++; $display("FAIL br_target: got %h/%h/%b want 20080041/00000044/1", instrD, pcplus4D, validD); end
    nChecks++; if (pcF !== 32'h44) begin nErrors++; $display("FAIL br_pc2: got %h want %h", pcF, 32'h44); end
  endtask

  task automatic test_jump_priority();
    jumpD = 1'b1; pcjumpD = 32'h100; pcsrcD = 1'b1; pcbranchD = 32'h80;
    step();
    nChecks++; if (pcF !== 32'h100) begin nErrors++; $display("FAIL jmp_prio: got %h want %h", pcF, 32'h100); end
    nChecks++; if (bubblecnt !== 32'd2) begin nErrors++; $display("FAIL jmp_cnt: got %0d want 2", bubblecnt); end
    pcsrcD = 1'b0; pcjumpD = 32'h20;
    step();
    jumpD = 1'b0;
    nChecks++; if (pcF !== 32'h20 || bubblecnt !== 32'd3) begin nErrors++; $display("FAIL jmp_20: got %h/%0d want 00000020/3", pcF, bubblecnt); end
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    step(); step();
    nChecks++; if (pcF !== 32'h20) begin nErrors++; $display("FAIL wait_pc: got %h want %h", pcF, 32'h20); end
    nChecks++; if (validD !== 1'b0 || instrD !== 32'h0) begin nErrors++; $display("FAIL wait_bubble: got %h/%b want 0/0", instrD, validD); end
    nChecks++; if (bubblecnt !== 32'd5 || fetchcnt !== 32'd5) begin nErrors++; $display("FAIL wait_cnt: got %0d/%0d want 5/5", fetchcnt, bubblecnt); end
    imem_ready = 1'b1;
    step();
    nChecks++; if (instrD !== 32'h2008_0021 || validD !== 1'b1 || pcF !== 32'h24) begin nErrors++; $display("FAIL wait_resume: got %h/%b/%h want 20080021/1/00000024", instrD, validD, pcF); end
    nChecks++; if (fetchcnt !== 32'd6) begin nErrors++; $display("FAIL wait_fcnt: got %0d want 6", fetchcnt); end
  endtask

  task automatic test_jump_during_wait();
    imem_ready = 1'b0; jumpD = 1'b1; pcjumpD = 32'h200;
    step();
    jumpD = 1'b0;
    nChecks++; if (pcF !== 32'h200 || bubblecnt !== 32'd6) begin nErrors++; $display("FAIL wjmp: got %h/%0d want 00000200/6", pcF, bubblecnt); end
    step();
    nChecks++; if (pcF !== 32'h200 || bubblecnt !== 32'd7) begin nErrors++; $display("FAIL wjmp_hold: got %h/%0d want 00000200/7", pcF, bubblecnt); end
    // Reset mid-wait with a coincident redirect: reset wins.
    reset = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h80;
    step();
    reset = 1'b0; pcsrcD = 1'b0;
    nChecks++; if (pcF !== 32'h0) begin nErrors++; $display("FAIL mid_reset_pc: got %h want %h", pcF, 32'h0); end
    nChecks++; if (fetchcnt !== 32'h0 || bubblecnt !== 32'h0 || validD !== 1'b0) begin nErrors++; $display("FAIL mid_reset_state: got %0d/%0d/%b want 0/0/0", fetchcnt, bubblecnt, validD); end
  endtask

  task automatic test_pc_wrap();
    imem_ready = 1'b1; jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
    step();
    jumpD = 1'b0;
    nChecks++; if (pcF !== 32'hFFFF_FFFC || bubblecnt !== 32'd1) begin nErrors++; $display("FAIL wrap_jmp: got %h/%0d want fffffffc/1", pcF, bubblecnt); end
    step();
    nChecks++; if (pcF !== 32'h0 || pcplus4D !== 32'h0) begin nErrors++; $display("FAIL wrap_pc: got %h/%h want 0/0", pcF, pcplus4D); end
    nChecks++; if (instrD !== 32'h2007_FFFD || validD !== 1'b1 || fetchcnt !== 32'd1) begin nErrors++; $display("FAIL wrap_id: got %h/%b/%0d want 2007fffd/1/1", instrD, validD, fetchcnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_imem_wait();
    test_jump_during_wait();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
